// File: rtl/mul_seq_24bit.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq_24bit
// Brief    : Sequential radix-2 shift-add multiplier for the ALU MUL path.
//            Returns the low WIDTH bits of a*b and flags nonzero upper bits.
//            Latency is fixed at WIDTH+1 cycles from start to done.
// Revision : 1.0 - initial release
// ============================================================================
module mul_seq_24bit #(
  parameter int WIDTH = 24
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             overflow
);

  // The counter must be able to hold WIDTH.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_product;
  logic               r_overflow;

  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_accept;

  // Accumulator value after the current iteration's conditional add.
  always_comb begin
    w_acc_next = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
  end

  // A new request is only taken while idle or in the completion cycle.
  assign w_accept = start && ((r_state == c_idle) || (r_state == c_done));

  // State machine plus shift-add datapath; reset wins over everything.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state    <= c_idle;
      r_mcand    <= '0;
      r_mplr     <= '0;
      r_acc      <= '0;
      r_count    <= '0;
      r_product  <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        c_idle, c_done: begin
          if (w_accept) begin
            r_mcand <= {{WIDTH{1'b0}}, a};
            r_mplr  <= b;
            r_acc   <= '0;
            r_count <= '0;
            r_state <= c_run;
          end else begin
            r_state <= c_idle;
          end
        end
        c_run: begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_count <= r_count + 1'b1;
          if (r_count == c_last) begin
            r_product  <= w_acc_next[WIDTH-1:0];
            r_overflow <= |w_acc_next[2*WIDTH-1:WIDTH];
            r_state    <= c_done;
          end
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign busy     = (r_state == c_run);
  assign done     = (r_state == c_done);
  assign product  = r_product;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_24bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_seq_24bit
// Brief    : Directed self-checking bench for mul_seq_24bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_seq_24bit;

  logic        Clock;
  logic        Resetn;
  logic        start;
  logic [23:0] a;
  logic [23:0] b;
  logic        busy;
  logic        done;
  logic [23:0] product;
  logic        overflow;

  int checks;
  int failures;

  mul_seq_24bit #(.WIDTH(24)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .overflow (overflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Present operands with start before an edge; returns #1 after that edge.
  task automatic launch(input logic [23:0] va, input logic [23:0] vb);
    @(negedge Clock);
    a     = va;
    b     = vb;
    start = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
  endtask

  // From #1 after the accept edge, count edges until done (bounded at 40).
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge Clock);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    start  = 1'b0;
    a      = 24'h0;
    b      = 24'h0;
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1'b1;
    checks++;
    if ({busy, done, product, overflow} !== 27'h0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b product=%h ovf=%b, want all 0",
               busy, done, product, overflow);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge Clock);
      #1;
      checks++;
      if ({busy, done, product, overflow} !== 27'h0) begin
        failures++;
        $display("FAIL reset_idle_hold cyc%0d: got busy=%b done=%b product=%h ovf=%b, want all 0",
                 i, busy, done, product, overflow);
      end
    end
  endtask

  task automatic test_basic();
    int lat, bc, extra_done;
    launch(24'd3, 24'd5);
    wait_done(lat, bc);
    checks++;
    if (lat !== 24) begin
      failures++;
      $display("FAIL basic_latency: got %0d edges, want 24", lat);
    end
    checks++;
    if (bc !== 24) begin
      failures++;
      $display("FAIL basic_busy_cycles: got %0d, want 24", bc);
    end
    checks++;
    if (busy !== 1'b0 || product !== 24'h00000F || overflow !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: got busy=%b product=%h ovf=%b, want 0/00000f/0",
               busy, product, overflow);
    end
    extra_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clock);
      #1;
      if (done) extra_done++;
    end
    checks++;
    if (extra_done !== 0 || product !== 24'h00000F) begin
      failures++;
      $display("FAIL basic_hold: got extra_done=%0d product=%h, want 0/00000f",
               extra_done, product);
    end
  endtask

  task automatic test_boundaries();
    int lat, bc;
    launch(24'hFFFFFF, 24'hFFFFFF);
    wait_done(lat, bc);
    checks++;
    if (product !== 24'h000001 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL max_operands: got product=%h ovf=%b, want 000001/1", product, overflow);
    end
    launch(24'h001000, 24'h001000);
    wait_done(lat, bc);
    checks++;
    if (product !== 24'h000000 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL pow2_overflow: got product=%h ovf=%b, want 000000/1", product, overflow);
    end
    launch(24'h000000, 24'hABCDEF);
    wait_done(lat, bc);
    checks++;
    if (product !== 24'h000000 || overflow !== 1'b0 || lat !== 24) begin
      failures++;
      $display("FAIL zero_operand: got product=%h ovf=%b lat=%0d, want 000000/0/24",
               product, overflow, lat);
    end
  endtask

  task automatic test_ignore_start();
    int          ndone;
    logic [23:0] seen;
    ndone = 0;
    seen  = 24'hDEAD00;
    launch(24'd7, 24'd6);
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        start = 1'b1;
        a     = 24'd2;
        b     = 24'd2;
      end else if (i == 6) begin
        start = 1'b0;
      end
      if (i >= 5 && i < 12) begin
        a = ~a;
        b = b ^ 24'h5A5A5A;
      end
      @(posedge Clock);
      #1;
      if (done) begin
        ndone++;
        seen = product;
      end
    end
    checks++;
    if (ndone !== 1) begin
      failures++;
      $display("FAIL ignore_start_done_count: got %0d pulses, want 1", ndone);
    end
    checks++;
    if (seen !== 24'h00002A) begin
      failures++;
      $display("FAIL ignore_start_product: got %h, want 00002a", seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    launch(24'd4, 24'd4);
    wait_done(lat, bc);
    checks++;
    if (done !== 1'b1 || product !== 24'h000010) begin
      failures++;
      $display("FAIL b2b_first: got done=%b product=%h, want 1/000010", done, product);
    end
    a     = 24'h000100;
    b     = 24'h000100;
    start = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_reenter: got busy=%b done=%b, want 1/0", busy, done);
    end
    wait_done(lat, bc);
    checks++;
    if (lat !== 24 || product !== 24'h010000 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d product=%h ovf=%b, want 24/010000/0",
               lat, product, overflow);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, ndone;
    launch(24'd9, 24'd9);
    repeat (10) @(posedge Clock);
    #1;
    Resetn = 1'b0;
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 24'h0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: got busy=%b done=%b product=%h ovf=%b, want 0/0/000000/0",
               busy, done, product, overflow);
    end
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge Clock);
      #1;
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d active cycles, want 0", ndone);
    end
    launch(24'd9, 24'd9);
    wait_done(lat, bc);
    checks++;
    if (product !== 24'h000051 || overflow !== 1'b0 || lat !== 24) begin
      failures++;
      $display("FAIL abort_retry: got product=%h ovf=%b lat=%0d, want 000051/0/24",
               product, overflow, lat);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_seq_24bit.md
Name: mul_seq_24bit

Overview:
Sequential radix-2 shift-add multiplier that produces the MUL result driven into the ALU result-select mux (mul input, select 3'b100).
- Replaces the combinational multiplier to shorten the critical path.
- Control stalls the single-cycle datapath while busy is high, then consumes product when done pulses.
- Returns the low 24 bits of the product plus an overflow flag for nonzero upper bits.

Parameters:
WIDTH, 24, operand and product width in bits. The full internal product is 2*WIDTH bits.

Ports:
Clock  input  1  system clock; all state updates on the rising edge
Resetn  input  1  synchronous, active-low reset
start  input  1  request a multiply; sampled only in IDLE or DONE
a  input  WIDTH  multiplicand; captured when start is accepted
b  input  WIDTH  multiplier; captured when start is accepted
busy  output  1  high while iterations are in progress (RUN state)
done  output  1  one-cycle pulse; product and overflow are valid from this cycle
product  output  WIDTH  low WIDTH bits of a*b; held until the next completion
overflow  output  1  high when the upper WIDTH bits of the 2*WIDTH product are nonzero; held with product

Behaviour:
- Reset: with Resetn=0 at a rising edge, the state goes to IDLE and busy=0, done=0, product=0, overflow=0, internal registers=0.
  - Reset has priority over every other event, including mid-RUN. An aborted operation produces no done pulse and leaves product=0.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - start=1 captures a into a 2*WIDTH shift register (zero-extended), b into a WIDTH shift register, clears the 2*WIDTH accumulator and the iteration counter, and moves to RUN.
  - start=0 stays in IDLE.
- RUN, one iteration per clock:
  - If mplr[0]=1, acc <= acc + mcand.
  - mcand <= mcand << 1; mplr <= mplr >> 1; count <= count + 1.
  - Addition is unsigned at 2*WIDTH bits and cannot wrap.
  - start is ignored; a and b may change freely.
- Final iteration (count = WIDTH-1 at the edge):
  - product <= low WIDTH bits of the post-add accumulator.
  - overflow <= OR of its upper WIDTH bits.
  - State moves to DONE.
- DONE:
  - done=1 and busy=0 for exactly this cycle.
  - With start=1, captures the new operands and goes to RUN (back-to-back); otherwise goes to IDLE.
- Latency: with start accepted at edge E, busy is high in the cycles after edges E .. E+WIDTH-1. The product loads at edge E+WIDTH, and done is high in the cycle after edge E+WIDTH (WIDTH+1 cycles from start to done).
- The product is the unsigned low half. This equals the two's-complement low half for signed operands, so MUL needs no sign handling. overflow is defined for unsigned interpretation only.
- Fixed latency: no early termination, including when an operand is zero.
- product and overflow change only at the final-iteration edge or on reset. busy and done are never high together.
- Counter width is clog2(WIDTH+1) bits.

Test Plan:
- Reset with Resetn=0 for 2 cycles, then release -> busy=0, done=0, product=0, overflow=0; with start=0 all outputs stay unchanged for 10 cycles.
- a=3, b=5, start pulsed for 1 cycle at edge E -> busy high for 24 cycles; done high only in the cycle after E+24; product=0x00000F, overflow=0; product still 0x00000F 10 cycles later.
- a=0xFFFFFF, b=0xFFFFFF -> full product 0xFFFFFE000001, so product=0x000001 and overflow=1. Then a=0x001000, b=0x001000 -> product=0x000000, overflow=1. Then a=0, b=0xABCDEF -> product=0, overflow=0, with done still exactly 25 cycles after start.
- Start a=7, b=6; at cycle 5 of RUN pulse start with a=2, b=2 and toggle a and b -> the second start is ignored; result is product=0x00002A and one done pulse only.
- Hold start=1 with a=0x000100, b=0x000100 during the DONE cycle of a prior op -> RUN re-entered with no IDLE cycle; next done 25 cycles later with product=0x010000, overflow=0.
- Start a=9, b=9, then assert Resetn=0 at RUN cycle 10 -> next cycle busy=0, done=0, product=0; no done pulse follows. A fresh 9*9 afterwards yields product=0x000051.
